// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding controller for a 5-stage RV32I pipeline.
// Tracks destination registers in EX/MEM/WB and resolves ID-stage source hazards.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_NUM   = 32,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic                       rs1_re,
    input  logic [$clog2(REG_NUM)-1:0] rs1_addr,
    input  logic                       rs2_re,
    input  logic [$clog2(REG_NUM)-1:0] rs2_addr,
    input  logic                       rd_we,
    input  logic [$clog2(REG_NUM)-1:0] rd_addr,
    input  logic                       id_is_load,
    input  logic                       ex_busy,
    input  logic                       ex_redirect,
    output logic                       if_id_en,
    output logic                       id_ex_en,
    output logic                       if_id_flush,
    output logic                       id_ex_bubble,
    output logic                       ex_mem_bubble,
    output logic [1:0]                 fwd_rs1_sel,
    output logic [1:0]                 fwd_rs2_sel,
    output logic [CNT_WIDTH-1:0]       stall_cnt,
    output logic [CNT_WIDTH-1:0]       flush_cnt
);

    typedef enum logic [1:0] {
        ACT_NORMAL,
        ACT_LOAD_STALL,
        ACT_REDIRECT,
        ACT_BUSY
    } act_e;

    logic                       ex_v, ex_ld, mem_v, mem_ld, wb_v;
    logic [$clog2(REG_NUM)-1:0] ex_rd, mem_rd, wb_rd;

    logic rs1_act, rs2_act;
    logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;
    logic load_stall;
    act_e act;

    // The register file bypasses WB writes itself, so the WB entry never feeds a decision.
    logic unused_sb;
    assign unused_sb = ^{wb_v, wb_rd, mem_ld};

    always_comb begin
        rs1_act    = id_valid && rs1_re && (rs1_addr != '0);
        rs2_act    = id_valid && rs2_re && (rs2_addr != '0);
        ex_hit1    = rs1_act && ex_v && (ex_rd == rs1_addr);
        ex_hit2    = rs2_act && ex_v && (ex_rd == rs2_addr);
        mem_hit1   = rs1_act && mem_v && (mem_rd == rs1_addr);
        mem_hit2   = rs2_act && mem_v && (mem_rd == rs2_addr);
        load_stall = ex_ld && (ex_hit1 || ex_hit2);

        if (rst)              act = ACT_NORMAL;
        else if (ex_busy)     act = ACT_BUSY;
        else if (ex_redirect) act = ACT_REDIRECT;
        else if (load_stall)  act = ACT_LOAD_STALL;
        else                  act = ACT_NORMAL;
    end

    always_comb begin
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        fwd_rs1_sel   = 2'd0;
        fwd_rs2_sel   = 2'd0;

        if (!rst) begin
            if (ex_hit1 && !ex_ld) fwd_rs1_sel = 2'd1;
            else if (mem_hit1)     fwd_rs1_sel = 2'd2;
            if (ex_hit2 && !ex_ld) fwd_rs2_sel = 2'd1;
            else if (mem_hit2)     fwd_rs2_sel = 2'd2;
        end

        case (act)
            ACT_BUSY: begin
                if_id_en      = 1'b0;
                id_ex_en      = 1'b0;
                ex_mem_bubble = 1'b1;
            end
            ACT_REDIRECT: begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end
            ACT_LOAD_STALL: begin
                if_id_en     = 1'b0;
                id_ex_bubble = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v      <= 1'b0;
            ex_ld     <= 1'b0;
            ex_rd     <= '0;
            mem_v     <= 1'b0;
            mem_ld    <= 1'b0;
            mem_rd    <= '0;
            wb_v      <= 1'b0;
            wb_rd     <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            wb_v  <= mem_v;
            wb_rd <= mem_rd;
            if (act == ACT_BUSY) begin
                // EX holds its occupant; MEM drains into WB and is backfilled with a bubble.
                mem_v  <= 1'b0;
                mem_ld <= 1'b0;
                mem_rd <= '0;
            end else begin
                mem_v  <= ex_v;
                mem_ld <= ex_ld;
                mem_rd <= ex_rd;
                if (act == ACT_NORMAL) begin
                    ex_v  <= id_valid && rd_we && (rd_addr != '0);
                    ex_ld <= id_valid && rd_we && (rd_addr != '0) && id_is_load;
                    ex_rd <= rd_addr;
                end else begin
                    ex_v  <= 1'b0;
                    ex_ld <= 1'b0;
                    ex_rd <= '0;
                end
            end

            if (!if_id_en && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            if ((act == ACT_REDIRECT) && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scenario bench for pipe_hazard_ctrl: per-cycle expected control vectors go through a
// scoreboard queue; counters are checked at the end of each scenario.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, rs1_re, rs2_re, rd_we, id_is_load, ex_busy, ex_redirect;
    logic [4:0]    rs1_addr, rs2_addr, rd_addr;
    logic          if_id_en, id_ex_en, if_id_flush, id_ex_bubble, ex_mem_bubble;
    logic [1:0]    fwd_rs1_sel, fwd_rs2_sel;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int unsigned passed = 0;
    int unsigned total  = 0;

    // {if_id_en, id_ex_en, if_id_flush, id_ex_bubble, ex_mem_bubble, fwd_rs1_sel, fwd_rs2_sel}
    logic [8:0] exp_q [$];

    typedef struct packed {
        logic       r;
        logic       v;
        logic       r1e;
        logic [4:0] r1;
        logic       r2e;
        logic [4:0] r2;
        logic       we;
        logic [4:0] rd;
        logic       ld;
        logic       bz;
        logic       rdr;
    } stim_t;

    pipe_hazard_ctrl #(.REG_NUM(32), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .rs1_re(rs1_re), .rs1_addr(rs1_addr),
        .rs2_re(rs2_re), .rs2_addr(rs2_addr), .rd_we(rd_we), .rd_addr(rd_addr),
        .id_is_load(id_is_load), .ex_busy(ex_busy), .ex_redirect(ex_redirect),
        .if_id_en(if_id_en), .id_ex_en(id_ex_en), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] obs();
        return {if_id_en, id_ex_en, if_id_flush, id_ex_bubble, ex_mem_bubble,
                fwd_rs1_sel, fwd_rs2_sel};
    endfunction

    function automatic stim_t mk(input logic r, input logic v, input logic r1e,
                                 input logic [4:0] r1, input logic r2e, input logic [4:0] r2,
                                 input logic we, input logic [4:0] rd, input logic ld,
                                 input logic bz, input logic rdr);
        stim_t s;
        s = '{r: r, v: v, r1e: r1e, r1: r1, r2e: r2e, r2: r2, we: we, rd: rd, ld: ld,
              bz: bz, rdr: rdr};
        return s;
    endfunction

    task automatic apply(input stim_t s);
        rst = s.r;         id_valid = s.v;
        rs1_re = s.r1e;    rs1_addr = s.r1;
        rs2_re = s.r2e;    rs2_addr = s.r2;
        rd_we = s.we;      rd_addr = s.rd;
        id_is_load = s.ld; ex_busy = s.bz;  ex_redirect = s.rdr;
    endtask

    task automatic do_reset();
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic test_reset();
        logic [8:0] got, want;
        apply(mk(1, 1, 1, 5'd3, 1, 5'd4, 1, 5'd5, 1, 1, 1));
        @(posedge clk); #1;
        exp_q.push_back(9'b110000000);
        @(negedge clk);
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) $display("FAIL reset_held outputs got %b want %b", got, want);
        else passed++;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(9'b110000000);
        #1;
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) $display("FAIL reset_release outputs got %b want %b", got, want);
        else passed++;
        total++;
        if (stall_cnt !== '0 || flush_cnt !== '0)
            $display("FAIL reset_counters got stall=%0d flush=%0d want 0/0", stall_cnt, flush_cnt);
        else passed++;
    endtask

    task automatic test_fwd_alu();
        stim_t st [3];
        logic [8:0] ex [3];
        logic [8:0] got, want;
        do_reset();
        st[0] = mk(0, 1, 1, 5'd1, 1, 5'd2, 1, 5'd5, 0, 0, 0);  ex[0] = 9'b110000000; // ADD x5,x1,x2
        st[1] = mk(0, 1, 1, 5'd5, 1, 5'd1, 1, 5'd6, 0, 0, 0);  ex[1] = 9'b110000100; // ADD x6,x5,x1
        st[2] = mk(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);  ex[2] = 9'b110000000;
        for (int i = 0; i < 3; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); total++;
            if (got !== want) $display("FAIL fwd_alu cyc%0d got %b want %b", i, got, want);
            else passed++;
            @(posedge clk); #1;
        end
        total++;
        if (stall_cnt !== 4'd0) $display("FAIL fwd_alu_stall_cnt got %0d want 0", stall_cnt);
        else passed++;
    endtask

    task automatic test_load_use();
        stim_t st [4];
        logic [8:0] ex [4];
        logic [8:0] got, want;
        do_reset();
        st[0] = mk(0, 1, 1, 5'd1, 0, 5'd0, 1, 5'd5, 1, 0, 0);  ex[0] = 9'b110000000; // LW x5
        st[1] = mk(0, 1, 1, 5'd5, 1, 5'd5, 1, 5'd6, 0, 0, 0);  ex[1] = 9'b010100000; // ADD x6,x5,x5
        st[2] = st[1];                                          ex[2] = 9'b110001010;
        st[3] = mk(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);  ex[3] = 9'b110000000;
        for (int i = 0; i < 4; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); total++;
            if (got !== want) $display("FAIL load_use cyc%0d got %b want %b", i, got, want);
            else passed++;
            @(posedge clk); #1;
        end
        total++;
        if (stall_cnt !== 4'd1) $display("FAIL load_use_stall_cnt got %0d want 1", stall_cnt);
        else passed++;
    endtask

    task automatic test_x0();
        stim_t st [2];
        logic [8:0] ex [2];
        logic [8:0] got, want;
        do_reset();
        st[0] = mk(0, 1, 1, 5'd0, 0, 5'd0, 1, 5'd0, 0, 0, 0);  ex[0] = 9'b110000000; // ADDI x0,x0,1
        st[1] = mk(0, 1, 1, 5'd0, 1, 5'd0, 1, 5'd7, 0, 0, 0);  ex[1] = 9'b110000000; // ADD x7,x0,x0
        for (int i = 0; i < 2; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); total++;
            if (got !== want) $display("FAIL x0 cyc%0d got %b want %b", i, got, want);
            else passed++;
            @(posedge clk); #1;
        end
        total++;
        if (stall_cnt !== 4'd0) $display("FAIL x0_stall_cnt got %0d want 0", stall_cnt);
        else passed++;
    endtask

    task automatic test_redirect_over_load();
        stim_t st [3];
        logic [8:0] ex [3];
        logic [8:0] got, want;
        do_reset();
        st[0] = mk(0, 1, 1, 5'd1, 0, 5'd0, 1, 5'd5, 1, 0, 0);  ex[0] = 9'b110000000; // LW x5
        st[1] = mk(0, 1, 1, 5'd5, 1, 5'd5, 1, 5'd6, 0, 0, 1);  ex[1] = 9'b111100000; // use + redirect
        st[2] = mk(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);  ex[2] = 9'b110000000;
        for (int i = 0; i < 3; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); total++;
            if (got !== want) $display("FAIL redirect cyc%0d got %b want %b", i, got, want);
            else passed++;
            @(posedge clk); #1;
        end
        total++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0)
            $display("FAIL redirect_counters got flush=%0d stall=%0d want 1/0", flush_cnt, stall_cnt);
        else passed++;
    endtask

    task automatic test_busy();
        stim_t st [6];
        logic [8:0] ex [6];
        logic [8:0] got, want;
        do_reset();
        st[0] = mk(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd3, 0, 0, 0);  ex[0] = 9'b110000000; // ADD x3
        st[1] = mk(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd4, 0, 0, 0);  ex[1] = 9'b110000000; // ADD x4
        st[2] = mk(0, 1, 1, 5'd3, 1, 5'd4, 1, 5'd8, 0, 1, 1);  ex[2] = 9'b000011001; // x3 in MEM
        st[3] = st[2];                                          ex[3] = 9'b000010001; // x3 gone
        st[4] = st[2];                                          ex[4] = 9'b000010001;
        st[5] = mk(0, 1, 1, 5'd3, 1, 5'd4, 1, 5'd8, 0, 0, 0);  ex[5] = 9'b110000001;
        for (int i = 0; i < 6; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); total++;
            if (got !== want) $display("FAIL busy cyc%0d got %b want %b", i, got, want);
            else passed++;
            @(posedge clk); #1;
        end
        total++;
        if (stall_cnt !== 4'd3 || flush_cnt !== 4'd0)
            $display("FAIL busy_counters got stall=%0d flush=%0d want 3/0", stall_cnt, flush_cnt);
        else passed++;
    endtask

    task automatic test_reset_mid_stall();
        stim_t st [5];
        logic [8:0] ex [5];
        logic [8:0] got, want;
        do_reset();
        st[0] = mk(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd3, 0, 0, 0);  ex[0] = 9'b110000000; // ADD x3
        st[1] = mk(0, 1, 1, 5'd1, 0, 5'd0, 1, 5'd5, 1, 0, 0);  ex[1] = 9'b110000000; // LW x5
        st[2] = mk(0, 1, 1, 5'd5, 1, 5'd3, 1, 5'd6, 0, 0, 0);  ex[2] = 9'b010100010; // load-use
        st[3] = mk(1, 1, 1, 5'd5, 1, 5'd3, 1, 5'd6, 0, 0, 0);  ex[3] = 9'b110000000; // rst
        st[4] = mk(0, 1, 1, 5'd5, 1, 5'd3, 1, 5'd6, 0, 0, 0);  ex[4] = 9'b110000000;
        for (int i = 0; i < 5; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            got = obs(); want = exp_q.pop_front(); total++;
            if (got !== want) $display("FAIL rst_mid_stall cyc%0d got %b want %b", i, got, want);
            else passed++;
            @(posedge clk); #1;
        end
        total++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0)
            $display("FAIL rst_mid_stall_counters got stall=%0d flush=%0d want 0/0",
                     stall_cnt, flush_cnt);
        else passed++;
    endtask

    task automatic test_saturate();
        logic [8:0] got, want;
        int unsigned bad = 0;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            apply(mk(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0));
            exp_q.push_back(9'b000010000);
            @(negedge clk);
            got = obs(); want = exp_q.pop_front();
            if (got !== want) bad++;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 17; i++) begin
            apply(mk(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1));
            exp_q.push_back(9'b111100000);
            @(negedge clk);
            got = obs(); want = exp_q.pop_front();
            if (got !== want) bad++;
            @(posedge clk); #1;
        end
        apply(mk(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0));
        total++;
        if (bad != 0) $display("FAIL saturate_outputs got %0d bad cycles want 0", bad);
        else passed++;
        total++;
        if (stall_cnt !== 4'hF || flush_cnt !== 4'hF)
            $display("FAIL saturate_counters got stall=%0d flush=%0d want 15/15",
                     stall_cnt, flush_cnt);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_fwd_alu();
        test_load_use();
        test_x0();
        test_redirect_over_load();
        test_busy();
        test_reset_mid_stall();
        test_saturate();
        total++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
